// File: rtl/cam_stream_pkg.sv
// rtl/cam_stream_pkg.sv - shared types and helpers for the camera frame streamer
package cam_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        PAD
    } cam_state_t;

    typedef struct packed {
        logic pad;
        logic sop;
        logic eop;
    } entry_flags_t;

    localparam int ENTRY_FLAG_W = 3;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cam_stream_fifo.sv
// rtl/cam_stream_fifo.sv - show-ahead synchronous FIFO with occupancy output
module cam_stream_fifo
    import cam_stream_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int DEPTH = 64,
    parameter int LVL_W = level_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    assign level_o = LVL_W'(wr_q - rd_q);
    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == FULL_LVL);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so a push while full is legal alongside it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/cam_frame_streamer.sv
// rtl/cam_frame_streamer.sv - camera pixel stream to Avalon-ST video packets (optional CAM_STREAM_TESTPAT_EN colour bars)
module cam_frame_streamer
    import cam_stream_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int CHANNELS   = 3,
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int FIFO_DEPTH = 64,
    parameter int ERR_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*PIX_W-1:0]      cam_data,
    input  logic                           cam_valid,
    input  logic                           cam_vs,
`ifdef CAM_STREAM_TESTPAT_EN
    input  logic [1:0]                     mode,
`else
    input  logic                           mode,
`endif
    input  logic                           capture_req,
    input  logic                           clear_status,
    output logic [CHANNELS*PIX_W-1:0]      st_data,
    output logic                           st_valid,
    output logic                           st_sop,
    output logic                           st_eop,
    input  logic                           st_ready,
    output logic                           img_captured,
    output logic                           busy,
    output logic                           overflow,
    output logic [ERR_W-1:0]               frame_err_cnt,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level
);

    localparam int DW    = CHANNELS * PIX_W;
    localparam int LVL_W = level_w(FIFO_DEPTH);
    localparam int XW    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int YW    = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    typedef struct packed {
        entry_flags_t  flags;
        logic [DW-1:0] data;
    } entry_t;

    cam_state_t        state_q, state_d;
    logic [XW-1:0]     x_q, x_d, cur_x;
    logic [YW-1:0]     y_q, y_d, cur_y;
    logic              vs_q;
    logic              ovf_q;
    logic [ERR_W-1:0]  err_q;
    logic              vs_rise, cont, first_px, last_px;
    logic              take, push, ovf_set, err_inc;
    cam_state_t        done_state;
    entry_t            wr_entry, head;
    logic [DW-1:0]     pix_data;
    logic              fifo_empty, fifo_full, pop;

    assign vs_rise    = cam_vs & ~vs_q;
    assign cur_x      = (state_q == ARMED) ? '0 : x_q;
    assign cur_y      = (state_q == ARMED) ? '0 : y_q;
    assign first_px   = (cur_x == '0) && (cur_y == '0);
    assign last_px    = (cur_x == XW'(FRAME_W - 1)) && (cur_y == YW'(FRAME_H - 1));

`ifdef CAM_STREAM_TESTPAT_EN
    function automatic logic [DW-1:0] colour_bars(input logic [XW-1:0] x);
        int bar;
        logic [DW-1:0] px;
        bar = (int'(x) * 8) / FRAME_W;
        for (int c = 0; c < CHANNELS; c++) begin
            px[c*PIX_W +: PIX_W] = (c < 3 && bar[c]) ? '1 : '0;
        end
        return px;
    endfunction

    assign cont     = mode[0];
    assign pix_data = mode[1] ? colour_bars(cur_x) : cam_data;
`else
    assign cont     = mode;
    assign pix_data = cam_data;
`endif

    assign done_state = cont ? ARMED : IDLE;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        take     = 1'b0;
        push     = 1'b0;
        ovf_set  = 1'b0;
        err_inc  = 1'b0;
        wr_entry = '0;
        case (state_q)
            IDLE: begin
                if (capture_req || cont) state_d = ARMED;
            end
            ARMED: begin
                if (vs_rise) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    take    = cam_valid;
                end
            end
            CAPTURE: begin
                // A new vsync before eop truncates; nothing written yet means nothing to close.
                if (vs_rise) state_d = first_px ? done_state : PAD;
                else         take    = cam_valid;
            end
            PAD: begin
                if (!fifo_full) begin
                    push           = 1'b1;
                    wr_entry.flags = '{pad: 1'b1, sop: 1'b0, eop: 1'b1};
                    err_inc        = 1'b1;
                    state_d        = done_state;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            if (fifo_full) begin
                ovf_set = 1'b1;
                state_d = first_px ? done_state : PAD;
            end else begin
                push           = 1'b1;
                wr_entry.flags = '{pad: 1'b0, sop: first_px, eop: last_px};
                wr_entry.data  = pix_data;
                if (last_px) begin
                    state_d = done_state;
                end else if (cur_x == XW'(FRAME_W - 1)) begin
                    x_d = '0;
                    y_d = cur_y + YW'(1);
                end else begin
                    x_d = cur_x + XW'(1);
                    y_d = cur_y;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vs_q    <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vs_q    <= cam_vs;
            if (clear_status)  ovf_q <= 1'b0;
            else if (ovf_set)  ovf_q <= 1'b1;
            if (clear_status)                 err_q <= '0;
            else if (err_inc && err_q != '1)  err_q <= err_q + ERR_W'(1);
        end
    end

    cam_stream_fifo #(
        .WIDTH (ENTRY_FLAG_W + DW),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    // Head memory is not reset, so the payload is masked while the FIFO is empty.
    assign st_valid      = !fifo_empty;
    assign st_data       = st_valid ? head.data : '0;
    assign st_sop        = st_valid & head.flags.sop;
    assign st_eop        = st_valid & head.flags.eop;
    assign pop           = st_valid & st_ready;
    assign img_captured  = pop & head.flags.eop & ~head.flags.pad;
    assign busy          = (state_q != IDLE);
    assign overflow      = ovf_q;
    assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_cam_frame_streamer.sv
// tb/tb_cam_frame_streamer.sv - self-checking bench for cam_frame_streamer
module tb_cam_frame_streamer;

    localparam int PIX_W = 8;
    localparam int CH    = 3;
    localparam int FW    = 4;
    localparam int FH    = 2;
    localparam int FD    = 4;
    localparam int ERR_W = 8;
    localparam int DW    = PIX_W * CH;
    localparam int LW    = 3;

    logic          clk;
    logic          reset;
    logic [DW-1:0] cam_data;
    logic          cam_valid;
    logic          cam_vs;
    logic          mode;
    logic          capture_req;
    logic          clear_status;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          st_sop;
    logic          st_eop;
    logic          st_ready;
    logic          img_captured;
    logic          busy;
    logic          overflow;
    logic [ERR_W-1:0] frame_err_cnt;
    logic [LW-1:0] fifo_level;

    cam_frame_streamer #(
        .PIX_W(PIX_W), .CHANNELS(CH), .FRAME_W(FW), .FRAME_H(FH),
        .FIFO_DEPTH(FD), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .cam_data(cam_data), .cam_valid(cam_valid),
        .cam_vs(cam_vs), .mode(mode), .capture_req(capture_req),
        .clear_status(clear_status), .st_data(st_data), .st_valid(st_valid),
        .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready),
        .img_captured(img_captured), .busy(busy), .overflow(overflow),
        .frame_err_cnt(frame_err_cnt), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          img;
    } beat_t;

    typedef struct {
        logic          vs;
        logic          valid;
        logic [DW-1:0] data;
        logic          push;
        logic          sop;
        logic          eop;
        logic          busy;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[11];
    int    checks  = 0;
    int    errors  = 0;
    int    img_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic s, input logic e, input logic i);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e; b.img = i;
        sb.push_back(b);
    endtask

    task automatic pix(input logic vs, input logic v, input logic [DW-1:0] d);
        cam_vs = vs; cam_valid = v; cam_data = d;
        tick();
    endtask

    task automatic pulse_capture();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    task automatic full_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FW*FH; i++) begin
            expect_beat(base + DW'(i), i == 0, i == FW*FH-1, i == FW*FH-1);
            pix(1'b1, 1'b1, base + DW'(i));
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || st_valid) && n < 200) begin
            tick();
            n++;
        end
        chk(name, {31'd0, (sb.size() == 0 && !st_valid)}, 32'd1);
    endtask

    // Output monitor: every accepted beat is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (st_valid && st_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", st_data);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("beat_data", {8'd0, st_data}, {8'd0, b.data});
                    chk("beat_sop", {31'd0, st_sop}, {31'd0, b.sop});
                    chk("beat_eop", {31'd0, st_eop}, {31'd0, b.eop});
                    chk("beat_img", {31'd0, img_captured}, {31'd0, b.img});
                end
            end else if (img_captured) begin
                chk("img_without_pop", {31'd0, img_captured}, 32'd0);
            end
            if (img_captured) img_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int img_snap;
        reset = 1'b1; cam_data = '0; cam_valid = 1'b0; cam_vs = 1'b0; mode = 1'b0;
        capture_req = 1'b0; clear_status = 1'b0; st_ready = 1'b0;

        // Single-shot frame vectors with a mid-frame gap carrying junk data.
        tbl[0]  = '{1'b1, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 24'h000001, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 24'h000002, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 24'h000003, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 24'h000004, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 24'h000005, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 24'h000006, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 24'h000007, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 24'h000008, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, st_valid}, 32'd0);
        chk("rst_sop", {31'd0, st_sop}, 32'd0);
        chk("rst_eop", {31'd0, st_eop}, 32'd0);
        chk("rst_data", {8'd0, st_data}, 32'd0);
        chk("rst_img", {31'd0, img_captured}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_err", {24'd0, frame_err_cnt}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        reset = 1'b0;
        tick();

        // Single-shot capture from the table.
        st_ready = 1'b1;
        pulse_capture();
        chk("s1_armed", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 11; i++) begin
            cam_vs = tbl[i].vs; cam_valid = tbl[i].valid; cam_data = tbl[i].data;
            if (tbl[i].push) expect_beat(tbl[i].data, tbl[i].sop, tbl[i].eop, tbl[i].eop);
            tick();
            chk($sformatf("s1_busy_%0d", i), {31'd0, busy}, {31'd0, tbl[i].busy});
        end
        wait_drain("s1_drain");
        chk("s1_img_cnt", img_cnt, 1);

        // Without a new capture_req a second frame must be ignored.
        pix(1'b1, 1'b1, 24'h000031);
        for (int i = 1; i < FW*FH; i++) pix(1'b1, 1'b1, 24'h000031 + DW'(i));
        pix(1'b0, 1'b0, '0);
        repeat (3) tick();
        chk("s1b_level", {29'd0, fifo_level}, 32'd0);
        chk("s1b_busy", {31'd0, busy}, 32'd0);
        chk("s1b_img_cnt", img_cnt, 1);

        // vs_rise and cam_valid together while ARMED: that pixel opens the packet.
        pulse_capture();
        full_frame(24'h000011);
        pix(1'b0, 1'b0, '0);
        wait_drain("s4_drain");
        chk("s4_img_cnt", img_cnt, 2);
        chk("s4_busy", {31'd0, busy}, 32'd0);

        // Backpressure overflow: four stored, fifth dropped, pad closes the packet.
        st_ready = 1'b0;
        pulse_capture();
        pix(1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_beat(24'h000021 + DW'(i), i == 0, 1'b0, 1'b0);
            if (i == 4) expect_beat('0, 1'b0, 1'b1, 1'b0);
            pix(1'b1, 1'b1, 24'h000021 + DW'(i));
        end
        pix(1'b0, 1'b0, '0);
        chk("s2_ovf", {31'd0, overflow}, 32'd1);
        chk("s2_level", {29'd0, fifo_level}, 32'd4);
        chk("s2_busy_pad", {31'd0, busy}, 32'd1);
        chk("s2_err_before", {24'd0, frame_err_cnt}, 32'd0);
        st_ready = 1'b1;
        wait_drain("s2_drain");
        chk("s2_err", {24'd0, frame_err_cnt}, 32'd1);
        chk("s2_busy", {31'd0, busy}, 32'd0);
        chk("s2_img_cnt", img_cnt, 2);

        // clear_status wins over an overflow set in the same cycle.
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("s6_ovf_clr", {31'd0, overflow}, 32'd0);
        chk("s6_err_clr", {24'd0, frame_err_cnt}, 32'd0);
        st_ready = 1'b0;
        pulse_capture();
        pix(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            expect_beat(24'h000041 + DW'(i), i == 0, 1'b0, 1'b0);
            pix(1'b1, 1'b1, 24'h000041 + DW'(i));
        end
        expect_beat('0, 1'b0, 1'b1, 1'b0);
        clear_status = 1'b1;
        pix(1'b1, 1'b1, 24'h000045);
        clear_status = 1'b0;
        chk("s6_ovf_same_cycle", {31'd0, overflow}, 32'd0);
        pix(1'b0, 1'b0, '0);
        st_ready = 1'b1;
        wait_drain("s6_drain");
        chk("s6_err", {24'd0, frame_err_cnt}, 32'd1);

        // Continuous mode: short frame, skipped frame, then a full frame.
        mode = 1'b1;
        tick();
        chk("s3_armed", {31'd0, busy}, 32'd1);
        pix(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            expect_beat(24'h000051 + DW'(i), i == 0, 1'b0, 1'b0);
            pix(1'b1, 1'b1, 24'h000051 + DW'(i));
        end
        pix(1'b0, 1'b0, '0);
        expect_beat('0, 1'b0, 1'b1, 1'b0);
        pix(1'b1, 1'b1, 24'h000054);
        for (int i = 0; i < 6; i++) pix(1'b1, 1'b1, 24'h000060 + DW'(i));
        pix(1'b0, 1'b0, '0);
        img_snap = img_cnt;
        pix(1'b1, 1'b0, '0);
        for (int i = 0; i < FW*FH; i++) begin
            if (i == 3) mode = 1'b0;
            expect_beat(24'h000071 + DW'(i), i == 0, i == FW*FH-1, i == FW*FH-1);
            pix(1'b1, 1'b1, 24'h000071 + DW'(i));
        end
        pix(1'b0, 1'b0, '0);
        wait_drain("s3_drain");
        chk("s3_err", {24'd0, frame_err_cnt}, 32'd2);
        chk("s3_img_cnt", img_cnt, img_snap + 1);
        chk("s3_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a capture with data still buffered.
        pulse_capture();
        pix(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            st_ready = (i < 2);
            expect_beat(24'h000091 + DW'(i), i == 0, 1'b0, 1'b0);
            pix(1'b1, 1'b1, 24'h000091 + DW'(i));
        end
        chk("s5_level_pre", {29'd0, fifo_level}, 32'd4);
        reset = 1'b1;
        #1;
        chk("s5_rst_valid", {31'd0, st_valid}, 32'd0);
        chk("s5_rst_eop", {31'd0, st_eop}, 32'd0);
        chk("s5_rst_data", {8'd0, st_data}, 32'd0);
        chk("s5_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("s5_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        cam_vs = 1'b0; cam_valid = 1'b0;
        tick();
        reset = 1'b0;
        st_ready = 1'b1;
        repeat (3) tick();
        chk("s5_post_level", {29'd0, fifo_level}, 32'd0);
        img_snap = img_cnt;
        pulse_capture();
        pix(1'b1, 1'b0, '0);
        full_frame(24'h000081);
        pix(1'b0, 1'b0, '0);
        wait_drain("s5_drain");
        chk("s5_img_cnt", img_cnt, img_snap + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_frame_streamer.md
Name: cam_frame_streamer

Overview:
Converts the raw camera pixel stream (valid-qualified pixels framed by vsync) into Avalon-ST video packets with sop/eop/valid/ready for the frame-buffer write path. Successor to the fixed 24-bit single-shot capture path: parametrised channel count, width, frame size and FIFO depth, with single-shot or continuous mode, backpressure buffering and truncated-frame recovery. Sits between the D8M pixel front-end and the VFB/SDRAM writer, all in one clock domain.

Parameters:
PIX_W, 8, bits per colour channel
CHANNELS, 3, channels per pixel; st_data width = CHANNELS*PIX_W
FRAME_W, 640, pixels per line
FRAME_H, 480, lines per frame
FIFO_DEPTH, 64, output FIFO entries; power of 2, >=4
ERR_W, 8, width of the saturating frame-error counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cam_data  in  CHANNELS*PIX_W  pixel data
cam_valid  in  1  pixel qualifier
cam_vs  in  1  vsync; a rising edge marks frame start
mode  in  1  0 = single-shot, 1 = continuous
capture_req  in  1  single-cycle pulse; arms a single-shot capture
clear_status  in  1  pulse; clears overflow and frame_err_cnt
st_data  out  CHANNELS*PIX_W  Avalon-ST data
st_valid  out  1  Avalon-ST valid
st_sop  out  1  start of packet
st_eop  out  1  end of packet
st_ready  in  1  sink ready, ready latency 0
img_captured  out  1  one-cycle pulse when a complete, untruncated frame's eop is accepted
busy  out  1  high in ARMED, CAPTURE and PAD
overflow  out  1  sticky; set on any dropped pixel
frame_err_cnt  out  ERR_W  saturating count of truncated frames
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: every output is 0; the FIFO is emptied; pixel counters are 0; state = IDLE; the vs edge register is 0. A reset mid-frame discards all buffered data. No partial packet is emitted after reset.
- vs_rise = cam_vs & ~cam_vs_q. A pixel arriving on the vs_rise cycle belongs to the new frame.
- States:
  - IDLE: move to ARMED on capture_req, or when mode=1.
  - ARMED: on vs_rise, move to CAPTURE with x=y=0. If cam_valid is high in the same cycle, that pixel is captured as pixel 0.
  - CAPTURE: each cam_valid writes {sop=(x==0&&y==0), eop=(x==FRAME_W-1&&y==FRAME_H-1), data}. x wraps at FRAME_W-1 and increments y.
    - After the eop write: go to ARMED if mode=1, else IDLE.
  - PAD: write one entry {sop=0, eop=1, data=0} as soon as the FIFO is not full. Then increment frame_err_cnt (saturating) and go to ARMED if mode=1, else IDLE. Frames whose vs_rise passes while in PAD are skipped.
- Truncation triggers in CAPTURE:
  - FIFO full on cam_valid: drop the pixel, set overflow, go to PAD.
  - vs_rise before eop: go to PAD; pixels in that cycle are dropped.
  - If the truncation occurs at pixel 0 (nothing written yet), skip PAD and return to ARMED/IDLE without counting an error.
- capture_req outside IDLE is ignored. Clearing mode mid-capture finishes the current frame, then goes to IDLE.
- FIFO: show-ahead. st_valid = !empty; st_data/st_sop/st_eop come from the head entry. Pop on st_valid&&st_ready. Write-to-st_valid latency is 1 cycle.
  - Simultaneous push and pop while full is allowed in the FIFO itself, but the capture side treats full as blocking (no push when full).
- img_captured: pulses in the cycle the eop beat is popped, only if that packet was not padded. A pad flag is stored per entry, so the FIFO is 3+CHANNELS*PIX_W bits wide.
- clear_status has priority over a same-cycle set.

Optional Feature:
CAM_STREAM_TESTPAT_EN
- Defined: the mode port becomes 2 bits. mode[1]=1 replaces cam_data with colour bars: channel c of pixel x = all-ones if bit c of (x*8/FRAME_W) is 1, else 0. Timing is still driven by cam_valid/cam_vs.
- Undefined: mode is 1 bit and no pattern logic exists.

Decomposition:
- Package cam_stream_pkg: state enum (IDLE, ARMED, CAPTURE, PAD), the FIFO entry struct {pad, sop, eop, data}, a clog2-based level-width constant.
- One sub-module: cam_stream_fifo, a parametrised show-ahead synchronous FIFO with level output.

Test Plan:
Bench parameters: FRAME_W=4, FRAME_H=2, FIFO_DEPTH=4, PIX_W=8, CHANNELS=3.
- Single-shot, st_ready=1: capture_req, vs_rise, 8 valid pixels 0x000001..0x000008 -> 8 beats, sop on 0x000001, eop on 0x000008, img_captured pulse once, return to IDLE; a second frame produces no output.
- Backpressure overflow: st_ready=0, 6 pixels -> 4 stored, overflow=1, PAD entry pushed after st_ready=1, packet of 5 beats ending {eop=1, data=0}, frame_err_cnt=1, no img_captured.
- Short frame, continuous mode: vs_rise after 3 pixels -> 4-beat packet with pad eop, next frame skipped, third frame complete with 8 beats.
- vs_rise with cam_valid in the same cycle while ARMED -> that pixel carries sop.
- Reset asserted mid-capture after 5 pixels -> all outputs 0 immediately, FIFO empty, no eop emitted, next capture_req gives a clean 8-beat frame.
- clear_status asserted the same cycle as an overflow event -> overflow reads 0 on the next cycle.
